// File: rtl/lac_pkg.sv
// lac_pkg: shared constants and FSM state type for the LAC result unloader
package lac_pkg;
  localparam int LAC_WIDTH = 8;
  localparam int LAC_N     = 512;
  localparam int LAC_Q     = 251;
  localparam int LAC_IDX_W = $clog2(LAC_N);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_ONE,
    ST_SEND_MONE,
    ST_SEND_DIFF
  } state_e;
endpackage

// File: rtl/lac_mod_sub.sv
// lac_mod_sub: combinational (a - b) mod Q for operands already reduced below Q
module lac_mod_sub #(
  parameter int WIDTH = 8,
  parameter int Q     = 251
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff
);
  logic [WIDTH:0] d;
  assign d      = {1'b0, i_a} - {1'b0, i_b} + ((i_a < i_b) ? (WIDTH+1)'(Q) : '0);
  assign o_diff = d[WIDTH-1:0];
endmodule

// File: rtl/lac_poly_unloader.sv
// lac_poly_unloader: snapshots multiplier results on done edge and streams them as valid/ready beats
// LAC_UNLOAD_DIFF_EN selects a single stream of (one - mone) mod Q instead of two raw streams.
module lac_poly_unloader
  import lac_pkg::*;
#(
  parameter int WIDTH = LAC_WIDTH,
  parameter int N     = LAC_N,
  parameter int Q     = LAC_Q
) (
  input  logic               i_clock,
  input  logic               i_rst_n,
  input  logic [WIDTH*N-1:0] i_sum_one,
  input  logic [WIDTH*N-1:0] i_sum_mone,
  input  logic               i_done,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sel,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_complete,
  output logic               o_drop
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WIDTH*N-1:0] one_q, one_d, mone_q, mone_d;
  logic               done_q, complete_q, complete_d, drop_q, drop_d;
  logic               start, hs, at_last;
  logic [WIDTH-1:0]   coeff_one, coeff_mone, coeff;
  assign start      = i_done & ~done_q;
  assign o_valid    = state_q != ST_IDLE;
  assign o_busy     = o_valid;
  assign hs         = o_valid & i_ready;
  assign at_last    = idx_q == LAST_IDX;
  assign coeff_one  = one_q[WIDTH*idx_q +: WIDTH];
  assign coeff_mone = mone_q[WIDTH*idx_q +: WIDTH];
`ifdef LAC_UNLOAD_DIFF_EN
  localparam state_e FIRST = ST_SEND_DIFF;
  lac_mod_sub #(.WIDTH(WIDTH), .Q(Q)) u_sub (
    .i_a   (coeff_one),
    .i_b   (coeff_mone),
    .o_diff(coeff)
  );
  assign o_sel  = 1'b0;
  assign o_last = (state_q == ST_SEND_DIFF) && at_last;
`else
  localparam state_e FIRST = ST_SEND_ONE;
  assign o_sel  = state_q == ST_SEND_MONE;
  assign coeff  = o_sel ? coeff_mone : coeff_one;
  assign o_last = (state_q == ST_SEND_MONE) && at_last;
`endif
  assign o_data     = o_valid ? coeff : '0;
  assign o_complete = complete_q;
  assign o_drop     = drop_q;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    one_d      = one_q;
    mone_d     = mone_q;
    complete_d = 1'b0;
    drop_d     = start & o_valid;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = FIRST;
        idx_d   = '0;
        one_d   = i_sum_one;
        mone_d  = i_sum_mone;
      end
    end else if (hs) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
      if (at_last) begin
        state_d    = (state_q == ST_SEND_ONE) ? ST_SEND_MONE : ST_IDLE;
        complete_d = state_q != ST_SEND_ONE;
      end
    end
  end
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      one_q      <= '0;
      mone_q     <= '0;
      done_q     <= 1'b0;
      complete_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      one_q      <= one_d;
      mone_q     <= mone_d;
      done_q     <= i_done;
      complete_q <= complete_d;
      drop_q     <= drop_d;
    end
  end
endmodule
